// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths and completer state encoding
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    typedef enum logic {
        SL_IDLE   = 1'b0,
        SL_ACCESS = 1'b1
    } apb_slv_state_t;

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - register bank with sync write, comb read, sync clear
module apb_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = (NUM_REGS < 2) ? 1 : $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (int'(widx) < NUM_REGS)) begin
            regs[widx] <= wdata;
        end
    end

    // Indices past the bank (non power-of-two sizes) read as zero
    always_comb begin
        rdata = '0;
        if (int'(ridx) < NUM_REGS) begin
            rdata = regs[ridx];
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB completer over a bank of 32-bit registers with fixed wait states
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                  NUM_REGS    = 8,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                  WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic [APB_ADDR_W-1:0] paddr_i,
    input  logic                  pwrite_i,
    input  logic [APB_DATA_W-1:0] pwdata_i,
    output logic [APB_DATA_W-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o
);

    localparam int WAIT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int IDX_W  = (NUM_REGS < 2) ? 1 : $clog2(NUM_REGS);

    apb_slv_state_t        state, next_state;
    logic [WAIT_W-1:0]     cnt;
    logic [APB_ADDR_W-1:0] off;
    logic [APB_ADDR_W-3:0] idx_full;
    logic                  addr_err;
    logic                  complete;
    logic [APB_DATA_W-1:0] rd_data;

    // Offset wraps, so addresses below the window fail both the compare and the range check
    assign off      = paddr_i - BASE_ADDR;
    assign idx_full = off[APB_ADDR_W-1:2];
    assign addr_err = (|paddr_i[1:0]) || (|off[1:0]) || (paddr_i < BASE_ADDR)
                   || ({2'b00, idx_full} >= APB_ADDR_W'(NUM_REGS));
    assign complete = (state == SL_ACCESS) && psel_i && penable_i && (cnt == '0);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= SL_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == SL_IDLE && psel_i && !penable_i) begin
                cnt <= WAIT_W'(WAIT_CYCLES);
            end else if (state == SL_ACCESS && psel_i && penable_i && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SL_IDLE: begin
                if (psel_i && !penable_i) begin
                    next_state = SL_ACCESS;
                end
            end
            SL_ACCESS: begin
                if (!psel_i || complete) begin
                    next_state = SL_IDLE;
                end
            end
            default: next_state = SL_IDLE;
        endcase
    end

    always_comb begin
        pready_o  = complete;
        pslverr_o = complete && addr_err;
        prdata_o  = '0;
        if (complete && !pwrite_i && !addr_err) begin
            prdata_o = rd_data;
        end
    end

    apb_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk   (pclk),
        .clr   (preset),
        .we    (complete && pwrite_i && !addr_err),
        .widx  (idx_full[IDX_W-1:0]),
        .wdata (pwdata_i),
        .ridx  (idx_full[IDX_W-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - scoreboard bench over three completer configurations
module tb_apb_reg_slave;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        pclk;
    logic        preset  [3];
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    exp_t q0[$], q1[$], q2[$];
    int n_cmp = 0;
    int n_bad = 0;

    apb_reg_slave #(.NUM_REGS(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .preset(preset[0]), .psel_i(psel[0]), .penable_i(penable[0]),
        .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
        .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]));

    apb_reg_slave #(.NUM_REGS(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_dut1 (
        .pclk(pclk), .preset(preset[1]), .psel_i(psel[1]), .penable_i(penable[1]),
        .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
        .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]));

    apb_reg_slave #(.NUM_REGS(8), .BASE_ADDR(32'h40), .WAIT_CYCLES(3)) u_dut2 (
        .pclk(pclk), .preset(preset[2]), .psel_i(psel[2]), .penable_i(penable[2]),
        .paddr_i(paddr[2]), .pwrite_i(pwrite[2]), .pwdata_i(pwdata[2]),
        .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endfunction

    function automatic void push(int d, exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: every response is matched against the oldest queued expectation
    always @(negedge pclk) begin
        for (int i = 0; i < 3; i++) begin
            if (preset[i] !== 1'b1) begin
                if (pready[i] === 1'b1) begin
                    if (qsize(i) == 0) begin
                        check($sformatf("unexpected_resp_dut%0d", i), 64'(pready[i]), 64'd0);
                    end else begin
                        exp_t e;
                        e = pop(i);
                        check($sformatf("resp_dut%0d", i), {31'd0, pslverr[i], prdata[i]},
                              {31'd0, e.err, e.rdata});
                    end
                end else begin
                    check($sformatf("idle_out_dut%0d", i), {31'd0, pslverr[i], prdata[i]}, 64'd0);
                end
            end
        end
    end

    // Caller is positioned just after a rising edge; returns just after the completing edge
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input bit ee, input int ew, input int hold);
        exp_t e;
        int   n;
        bit   done;
        e.rdata = er;
        e.err   = ee;
        push(d, e);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a;
        pwdata[d]  = wd;
        repeat (hold) begin
            @(posedge pclk); #1;
        end
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge pclk);
            n++;
            if (pready[d] === 1'b1) done = 1'b1;
        end
        check($sformatf("latency_dut%0d_a%h", d, a), 64'(done ? n : 0), 64'(ew + 1));
        @(posedge pclk); #1;
    endtask

    task automatic idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        @(posedge pclk); #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            preset[i] = 1'b1; psel[i] = 1'b0; penable[i] = 1'b0;
            pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
        end
        @(posedge pclk);
        @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_out_dut%0d", i),
                  {30'd0, pready[i], pslverr[i], prdata[i]}, 64'd0);
        end
        @(posedge pclk); #1;
        for (int i = 0; i < 3; i++) preset[i] = 1'b0;
        @(posedge pclk); #1;

        // Zero-wait write then read
        xfer(0, 1, 32'h4, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
        xfer(0, 0, 32'h4, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        idle(0);

        // Two wait states
        xfer(1, 0, 32'h0, 32'h0, 32'h0, 0, 2, 0);
        idle(1);

        // Out-of-range and misaligned accesses, bank untouched
        xfer(0, 0, 32'h20, 32'h0, 32'h0, 1, 0, 0);
        xfer(0, 1, 32'h6, 32'h1234, 32'h0, 1, 0, 0);
        for (int r = 0; r < 8; r++) begin
            xfer(0, 0, 32'(4 * r), 32'h0, (r == 1) ? 32'hDEAD_BEEF : 32'h0, 0, 0, 0);
        end
        idle(0);

        // Back-to-back write then read
        xfer(0, 1, 32'h1C, 32'hA5A5_A5A5, 32'h0, 0, 0, 0);
        xfer(0, 0, 32'h1C, 32'h0, 32'hA5A5_A5A5, 0, 0, 0);
        idle(0);

        // Non-zero window base
        xfer(2, 0, 32'h3C, 32'h0, 32'h0, 1, 3, 0);
        xfer(2, 1, 32'h5C, 32'h77, 32'h0, 0, 3, 0);
        xfer(2, 0, 32'h5C, 32'h0, 32'h77, 0, 3, 0);
        xfer(2, 0, 32'h60, 32'h0, 32'h0, 1, 3, 0);
        idle(2);

        // Reset mid-transfer discards the write and clears the bank
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h48; pwdata[2] = 32'hFFFF_FFFF;
        @(posedge pclk); #1;
        penable[2] = 1'b1;
        @(posedge pclk); #1;
        preset[2] = 1'b1;
        @(posedge pclk); #1;
        preset[2] = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
        @(negedge pclk);
        check("pready_after_reset", 64'(pready[2]), 64'd0);
        @(posedge pclk); #1;
        xfer(2, 0, 32'h48, 32'h0, 32'h0, 0, 3, 0);
        xfer(2, 0, 32'h5C, 32'h0, 32'h0, 0, 3, 0);
        idle(2);

        // psel dropped during a wait cycle aborts silently
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'hC; pwdata[1] = 32'h0BAD;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge pclk); #1;
        xfer(1, 0, 32'hC, 32'h0, 32'h0, 0, 2, 0);
        idle(1);

        // penable held low in ACCESS freezes the wait counter
        xfer(1, 1, 32'hC, 32'h55, 32'h0, 0, 2, 2);
        xfer(1, 0, 32'hC, 32'h0, 32'h55, 0, 2, 0);
        idle(1);

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("queues_drained", 64'(qsize(0) + qsize(1) + qsize(2)), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
